// File: rtl/id_exe_pkg.sv
// Shared types for the ID/EXE pipeline register: the packed control word,
// the EXE command encodings and field widths.
package id_exe_pkg;

  localparam int DEST_W = 4;
  localparam int CTRL_W = 16;

  localparam logic [3:0] EXE_CMD_NOP = 4'h0;
  localparam logic [3:0] EXE_CMD_MOV = 4'h1;
  localparam logic [3:0] EXE_CMD_ADD = 4'h2;
  localparam logic [3:0] EXE_CMD_ADC = 4'h3;
  localparam logic [3:0] EXE_CMD_SUB = 4'h4;
  localparam logic [3:0] EXE_CMD_SBC = 4'h5;
  localparam logic [3:0] EXE_CMD_AND = 4'h6;
  localparam logic [3:0] EXE_CMD_ORR = 4'h7;
  localparam logic [3:0] EXE_CMD_EOR = 4'h8;
  localparam logic [3:0] EXE_CMD_MVN = 4'h9;

  // wb_en is bit 15, rsvd occupies bits 5:0.
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic       s;
    logic       b;
    logic       imm;
    logic [5:0] rsvd;
  } id_exe_ctrl_t;

  localparam id_exe_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_exe_slot.sv
// One pipeline slot: a valid bit plus a payload register, with load and clear.
// Clear wins over load so a flush can never be overridden by a transfer.
module id_exe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic         i_clear,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; the payload is reset too, so out_* read zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/id_exe_reg.sv
// ID->EXE pipeline register as a two-slot skid buffer: full throughput, with
// in_ready derived only from the skid register, flush for taken branches.
module id_exe_reg
  import id_exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [DATA_W-1:0] in_instruction,
  input  logic [DATA_W-1:0] in_val_rn,
  input  logic [DATA_W-1:0] in_val_rm,
  input  logic [DEST_W-1:0] in_dest,
  input  id_exe_ctrl_t      in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instruction,
  output logic [DATA_W-1:0] out_val_rn,
  output logic [DATA_W-1:0] out_val_rm,
  output logic [DEST_W-1:0] out_dest,
  output id_exe_ctrl_t      out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int PAY_W = 4 * DATA_W + DEST_W + CTRL_W;
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  logic             w_main_valid, w_skid_valid;
  logic [PAY_W-1:0] w_main_data, w_skid_data, w_in_payload, w_main_next;
  logic             w_accept, w_main_load, w_main_clear, w_skid_load, w_skid_clear;
  id_exe_ctrl_t     w_main_ctrl;
  logic [CNT_W-1:0] r_stall_count;

  assign w_in_payload = {in_pc, in_instruction, in_val_rn, in_val_rm, in_dest, in_ctrl};

  assign in_ready = ~w_skid_valid;
  assign w_accept = in_valid & in_ready & ~flush;

  // A full skid always drains into main first, so it never competes with in.
  assign w_main_load  = ~flush & ((w_skid_valid & out_ready) |
                                  (w_accept & (~w_main_valid | out_ready)));
  assign w_main_next  = w_skid_valid ? w_skid_data : w_in_payload;
  assign w_main_clear = flush | (w_main_valid & out_ready & ~w_skid_valid & ~w_accept);

  assign w_skid_load  = w_accept & w_main_valid & ~out_ready;
  assign w_skid_clear = flush | (w_skid_valid & out_ready);

  id_exe_slot #(.W(PAY_W)) u_main (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_main_load),
    .i_clear (w_main_clear),
    .i_data  (w_main_next),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  id_exe_slot #(.W(PAY_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_data  (w_in_payload),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  assign {out_pc, out_instruction, out_val_rn, out_val_rm, out_dest, w_main_ctrl} = w_main_data;
  assign out_valid = w_main_valid;
  // A bubble must never carry write-back or memory enables into EXE.
  assign out_ctrl  = w_main_valid ? w_main_ctrl : CTRL_BUBBLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (in_valid && !in_ready && !flush && r_stall_count != STALL_MAX) begin
      r_stall_count <= r_stall_count + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_id_exe_reg.sv
// Self-checking bench for id_exe_reg: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_id_exe_reg;
  import id_exe_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] in_pc, in_instruction, in_val_rn, in_val_rm;
  logic [3:0]    in_dest;
  id_exe_ctrl_t  in_ctrl;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_pc, out_instruction, out_val_rn, out_val_rm;
  logic [3:0]    out_dest;
  id_exe_ctrl_t  out_ctrl;
  logic [15:0]   stall_count;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_pc, s_out_instruction, s_out_val_rn, s_out_val_rm;
  logic [3:0]    s_out_dest;
  id_exe_ctrl_t  s_out_ctrl;
  logic [3:0]    s_stall_count;

  always #5 clk = ~clk;

  id_exe_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instruction(in_instruction),
    .in_val_rn(in_val_rn), .in_val_rm(in_val_rm),
    .in_dest(in_dest), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .out_val_rn(out_val_rn), .out_val_rm(out_val_rm),
    .out_dest(out_dest), .out_ctrl(out_ctrl),
    .stall_count(stall_count)
  );

  id_exe_reg #(.DATA_W(32), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_pc(in_pc), .in_instruction(in_instruction),
    .in_val_rn(in_val_rn), .in_val_rm(in_val_rm),
    .in_dest(in_dest), .in_ctrl(in_ctrl),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_pc(s_out_pc), .out_instruction(s_out_instruction),
    .out_val_rn(s_out_val_rn), .out_val_rm(s_out_val_rm),
    .out_dest(s_out_dest), .out_ctrl(s_out_ctrl),
    .stall_count(s_stall_count)
  );

  typedef struct packed {
    logic [31:0] pc, instr, rn, rm;
    logic [3:0]  dest;
    logic [15:0] ctrl;
  } beat_t;

  // Reference model: an in-order queue of at most two beats.
  beat_t       q[$];
  beat_t       last_head;
  int unsigned m_stall16, m_stall4;
  bit          m_accepted;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_head  = '0;
    m_stall16  = 0;
    m_stall4   = 0;
    m_accepted = 1'b0;
  endtask

  task automatic model_step();
    bit acc;
    acc = in_valid && (q.size() < 2) && !flush;
    if (in_valid && q.size() == 2 && !flush) begin
      if (m_stall16 < 65535) m_stall16++;
      if (m_stall4 < 15) m_stall4++;
    end
    if (flush) begin
      q.delete();
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back({in_pc, in_instruction, in_val_rn, in_val_rm, in_dest, in_ctrl});
    end
    if (q.size() > 0) last_head = q[0];
    m_accepted = acc;
  endtask

  always @(posedge clk) if (rst_n) model_step();

  always @(negedge clk) begin
    bit ev;
    ev = (q.size() > 0);
    check("out_valid",   out_valid, ev);
    check("in_ready",    in_ready, q.size() < 2);
    check("out_pc",      out_pc, last_head.pc);
    check("out_instr",   out_instruction, last_head.instr);
    check("out_val_rn",  out_val_rn, last_head.rn);
    check("out_val_rm",  out_val_rm, last_head.rm);
    check("out_dest",    out_dest, last_head.dest);
    check("out_ctrl",    out_ctrl, ev ? last_head.ctrl : 16'h0);
    check("stall_count", stall_count, m_stall16);
    check("sat_stall",   s_stall_count, m_stall4);
    check("sat_out_pc",  s_out_pc, last_head.pc);
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] pc, input logic [15:0] ctrl);
    in_pc          = pc;
    in_instruction = $urandom;
    in_val_rn      = $urandom;
    in_val_rm      = $urandom;
    in_dest        = 4'($urandom);
    in_ctrl        = ctrl;
  endtask

  initial begin
    bit keep;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instruction = '0; in_val_rn = '0; in_val_rm = '0;
    in_dest = '0; in_ctrl = '0;
    model_reset();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_ctrl",  out_ctrl, 0);
    check("rst_stall",     stall_count, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back streaming with a one-cycle latency.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set_beat(32'(4 * i), (i == 7) ? 16'hA000 : 16'($urandom));
      in_valid = 1'b1;
      tick();
      check("stream_valid", out_valid, 1);
      check("stream_pc", out_pc, 32'(4 * i));
      if (i == 7) check("stream_ctrl7", out_ctrl, 16'hA000);
    end
    in_valid = 1'b0;
    tick();
    check("bubble_valid", out_valid, 0);
    check("bubble_ctrl",  out_ctrl, 16'h0000);
    check("bubble_pc",    out_pc, 32'h1C);

    // Backpressure: 0x14 parks in skid, 0x18 waits upstream.
    set_beat(32'h10, 16'($urandom)); in_valid = 1'b1;
    tick();
    check("bp_main_pc", out_pc, 32'h10);
    out_ready = 1'b0;
    set_beat(32'h14, 16'($urandom));
    tick();
    check("bp_skid_ready", in_ready, 0);
    check("bp_hold_pc", out_pc, 32'h10);
    set_beat(32'h18, 16'($urandom));
    repeat (3) tick();
    check("bp_stall3", stall_count, 3);
    check("bp_still_pc", out_pc, 32'h10);
    out_ready = 1'b1;
    tick();
    check("bp_drain_pc", out_pc, 32'h14);
    check("bp_drain_ready", in_ready, 1);
    check("bp_stall4", stall_count, 4);
    tick();
    check("bp_last_pc", out_pc, 32'h18);
    in_valid = 1'b0;
    tick();
    check("bp_empty", out_valid, 0);

    // Flush with both slots full and a beat on the input.
    out_ready = 1'b0;
    set_beat(32'h20, 16'hE000); in_valid = 1'b1;
    tick();
    set_beat(32'h24, 16'hE000);
    tick();
    set_beat(32'h28, 16'hE000); flush = 1'b1;
    tick();
    check("fl_valid", out_valid, 0);
    check("fl_ctrl",  out_ctrl, 0);
    check("fl_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    check("fl_none", out_valid, 0);
    check("fl_stall", stall_count, 4);

    // Saturation of the 4-bit counter over a 20-cycle stall.
    out_ready = 1'b0;
    set_beat(32'h30, 16'($urandom)); in_valid = 1'b1;
    tick();
    set_beat(32'h34, 16'($urandom));
    tick();
    set_beat(32'h38, 16'($urandom));
    repeat (20) tick();
    check("sat_15", s_stall_count, 15);
    check("sat_wide_24", stall_count, 24);

    // Reset mid-stream drops both held beats immediately.
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mrst_valid", out_valid, 0);
    check("mrst_ctrl",  out_ctrl, 0);
    check("mrst_ready", in_ready, 1);
    check("mrst_stall", stall_count, 0);
    check("mrst_pc",    out_pc, 0);
    tick();
    rst_n = 1'b1;
    set_beat(32'h40, 16'($urandom)); out_ready = 1'b1; in_valid = 1'b1;
    tick();
    check("mrst_first_pc", out_pc, 32'h40);
    in_valid = 1'b0;
    tick();

    // Randomized traffic; a stalled beat stays on the input until taken.
    for (int i = 0; i < 3000; i++) begin
      keep = in_valid && !m_accepted && !flush;
      if (!keep) begin
        set_beat($urandom, 16'($urandom));
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      if (i == 1500) begin
        rst_n = 1'b0;
        model_reset();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of pc, instruction and operand fields.
REQ-002 SHALL have parameter CNT_W, default 16, width of stall counter.
REQ-003 SHALL have one clock; reset is asynchronous and active-low: clk input 1, rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 flush  input  1  kill all held and incoming beats (taken branch).
REQ-006 in_valid  input  1  decode beat present.
REQ-007 in_ready  output  1  register can accept a beat.
REQ-008 in_pc, in_instruction, in_val_rn, in_val_rm  input  DATA_W each  decode payload.
REQ-009 in_dest  input  4  destination register index.
REQ-010 in_ctrl  input  id_exe_ctrl_t (16)  packed control: wb_en, mem_r_en, mem_w_en, exe_cmd[3:0], s, b, imm, rsvd[5:0].
REQ-011 out_valid  output  1  beat presented to EXE_STAGE.
REQ-012 out_ready  input  1  EXE side accepts.
REQ-013 out_pc, out_instruction, out_val_rn, out_val_rm, out_dest, out_ctrl  output  same widths as inputs  held payload.
REQ-014 stall_count  output  CNT_W  saturating count of upstream stall cycles.

Function
REQ-015 Transfer occurs on a rising edge when valid and ready are both 1 on that side; no other condition moves data.
REQ-016 SHALL hold two slots: main (drives out_*) and skid; beats leave in arrival order.
REQ-017 in_ready SHALL equal NOT skid_valid, registered; no combinational path from out_ready or flush to in_ready.
REQ-018 Main empty + accept: beat enters main; out_valid=1 next cycle (latency 1).
REQ-019 Main full, out_ready=1, skid empty, accept: new beat replaces main same edge (throughput 1/cycle).
REQ-020 Main full, out_ready=0, accept: beat enters skid; in_ready=0 next cycle.
REQ-021 Skid full, out_ready=1: main<=skid, skid empties, in_ready=1 next cycle; in_valid ignored that cycle.
REQ-022 Main full, out_ready=0, no accept: main and out_* hold stable, bit-exact.
REQ-023 Main full, out_ready=1, no accept, skid empty: main empties; out_valid=0 next cycle.
REQ-024 out_ctrl SHALL be forced to all-zero whenever out_valid=0 (bubble: no wb/mem side effects); other out_* hold last value.
REQ-025 flush=1 SHALL clear main_valid and skid_valid at the edge, discard the concurrent in beat, and have priority over all transfers; in_ready=1 next cycle.
REQ-026 stall_count SHALL increment each cycle with in_valid=1, in_ready=0, flush=0; saturates at 2^CNT_W-1; no wrap.
REQ-027 Payload SHALL pass unmodified; no arithmetic on data fields.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear main_valid, skid_valid, all payload registers and stall_count to 0; in_ready=1, out_valid=0, all out_* = 0.
REQ-029 Reset mid-operation SHALL drop held beats without emitting them; first accept after release enters main.

Structure
REQ-030 Package id_exe_pkg SHALL hold id_exe_ctrl_t, EXE_CMD_* encodings, DEST_W=4, CTRL_W=16.
REQ-031 One sub-module id_exe_slot (valid bit + payload register with load/clear) SHALL be instantiated twice (main, skid).

Verification
REQ-032 Reset: rst_n=0 mid-stream -> out_valid=0, out_ctrl=0, in_ready=1, stall_count=0 immediately.
REQ-033 Streaming: out_ready=1, 8 beats pc=0x00,0x04..0x1C back-to-back -> same pcs out in order, one per cycle, 1-cycle latency.
REQ-034 Backpressure: out_ready=0 after beat pc=0x10, beats 0x14,0x18 offered -> 0x14 in skid, in_ready=0, 0x18 held upstream; stall_count increments per cycle; release -> 0x10,0x14,0x18 in order, none lost or duplicated.
REQ-035 Flush: main=0x20, skid=0x24, flush=1 with in pc=0x28 -> out_valid=0, out_ctrl=0 next cycle, 0x20/0x24/0x28 never emitted, in_ready=1.
REQ-036 Bubble: in_ctrl wb_en=1,mem_w_en=1, beat consumed, no new beat -> out_ctrl=0x0000, out_pc holds last value.
REQ-037 Saturation: CNT_W=4, hold stall 20 cycles -> stall_count stops at 15.
